soc_system_pio_pulse_seq: RTL and testbench
===========================================

Name: soc_system_pio_pulse_seq

Overview:
- Avalon-MM master-side sequencer that drives a 1-bit output PIO slave (s1: address/chipselect/write_n/writedata) to generate a programmed train of level pulses, e.g. on the clk_HPS PIO line.
- Sits in the FPGA fabric beside the PIO. Fabric logic supplies start, half-period and pulse count; the sequencer issues single-cycle writes of 1/0 with exact cycle spacing.
- Sole writer of the PIO data register while busy.

Parameters:
- CNT_W, 16, width of half_period and of the phase counter
- NUM_W, 16, width of num_pulses and pulses_left
- IDLE_LEVEL, 0, PIO level written at init, at completion and on abort

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- abort  in  1  terminate the current train
- half_period  in  CNT_W  cycles per high phase and per low phase; 0 is treated as 1
- num_pulses  in  NUM_W  high pulses to emit
- busy  out  1  sequence in progress
- done  out  1  one-cycle strobe at end of train, whether completed or aborted
- pulses_left  out  NUM_W  pulses still to finish
- level  out  1  shadow of the last value written to the PIO
- avm_address  out  2  PIO register address; always 2'd0
- avm_chipselect  out  1  write strobe qualifier
- avm_write_n  out  1  active-low write
- avm_writedata  out  32  {31'b0, bit}

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are named clk and reset.
- All outputs are registered.
- Idle bus: avm_chipselect=0, avm_write_n=1, avm_writedata=0, avm_address=0.
- Write cycle: exactly one cycle with chipselect=1, write_n=0, address=0, writedata={31'b0,bit}. The PIO has no waitrequest, so each write completes in that cycle.
- Reset values: busy=0, done=0, pulses_left=0, level=IDLE_LEVEL, bus idle, state=INIT.
- States: INIT, IDLE, WR_HI, WAIT_HI, WR_LO, WAIT_LO, FINISH.
- INIT: one write of IDLE_LEVEL, then IDLE. This resyncs the PIO, whose reset is independent. busy=1 in INIT.
- IDLE, start=1, abort=0:
  - Latch hp=max(half_period,1) and n=num_pulses.
  - If n==0, go to FINISH (no writes). Otherwise go to WR_HI with pulses_left=n.
- start=1 together with abort=1 in IDLE: ignored. start while not in IDLE: ignored.
- WR_HI: write 1, level<=1. If hp==1 go to WR_LO, else WAIT_HI with counter=hp-1.
- WAIT_HI: decrement the counter; when it reaches 1, go to WR_LO. The high phase is exactly hp cycles, write to write.
- WR_LO: write 0, level<=0, pulses_left<=pulses_left-1. Then WAIT_LO, or skip it when hp==1.
- WAIT_LO, end of count:
  - If pulses_left==0, go to FINISH.
  - Otherwise go to WR_HI. The low phase is exactly hp cycles.
- Timing: with start sampled at cycle 0, the k-th (0-based) high write is at cycle 1+2k·hp. done is asserted at cycle 1+2n·hp.
- FINISH: done=1 for one cycle, busy=0, then IDLE.
- busy=1 in INIT, WR_*, WAIT_*; busy=0 in IDLE and FINISH.
- abort in any WR_*/WAIT_* state, taking priority over the transition that cycle:
  - If level==1, or a WR_HI write occurs that cycle, go to WR_LO-abort (write IDLE_LEVEL, pulses_left<=0), then FINISH.
  - Otherwise go straight to FINISH.
  - A train never ends with the PIO high when IDLE_LEVEL=0.
- abort in INIT: ignored.
- reset mid-train: immediate return to INIT next cycle; no done.
- pulses_left never wraps below 0. The counter is CNT_W bits; hp=2^CNT_W-1 is legal.

Optional Feature:
- Macro: PULSE_SEQ_CONTINUOUS_EN.
- Defined: num_pulses==0 at start means an endless train. pulses_left stays 0 and is not decremented; the train ends only by abort, which ends with an IDLE_LEVEL write and a done strobe.
- Undefined: num_pulses==0 produces an immediate FINISH (done one cycle after start, no bus writes).

Decomposition:
- Package soc_system_pio_seq_pkg holds:
  - state enum (INIT..FINISH)
  - localparam PIO_DATA_ADDR=2'd0
  - localparams for the write encodings of 1 and 0
- Sub-module soc_system_pio_seq_timer: loadable CNT_W down-counter with a load/expire interface, used for both phases.

Test Plan:
- Reset release -> exactly one write of 0 at address 0 during INIT; busy=1 for 1 cycle, then IDLE.
- hp=3, n=2, start at cycle 0:
  - writes 1@1, 0@4, 1@7, 0@10
  - done@13, pulses_left sequence 2→1→0
- hp=0, n=3 -> behaves as hp=1: alternating 1/0 writes on consecutive cycles, 6 writes, done 7 cycles after start.
- hp=10, n=5, abort in WAIT_HI of pulse 2 -> next cycle write 0, then done; pulses_left=0, level=0, no further writes.
- n=0 without the macro -> done one cycle after start, no writes. With the macro -> continuous toggling until abort.
- start pulsed while busy, and start+abort together in IDLE -> ignored, no change in schedule; reset asserted mid-WAIT_LO -> bus idle next cycle, then INIT write of 0.

Source files
------------

// File: rtl/soc_system_pio_seq_pkg.sv
// Shared types and constants for the PIO pulse sequencer: state encoding,
// the PIO data register address and the two data words written to it.
package soc_system_pio_seq_pkg;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_WR_HI   = 3'd2,
    ST_WAIT_HI = 3'd3,
    ST_WR_LO   = 3'd4,
    ST_WAIT_LO = 3'd5,
    ST_FINISH  = 3'd6
  } seq_state_e;

  localparam logic [1:0]  PIO_DATA_ADDR  = 2'd0;
  localparam logic [31:0] PIO_WDATA_ONE  = 32'h0000_0001;
  localparam logic [31:0] PIO_WDATA_ZERO = 32'h0000_0000;

  // Map a 1-bit PIO level onto the 32-bit data word.
  function automatic logic [31:0] pio_wdata(input logic b);
    return b ? PIO_WDATA_ONE : PIO_WDATA_ZERO;
  endfunction

endpackage

// File: rtl/soc_system_pio_seq_timer.sv
// Loadable down-counter timing one phase of the pulse train. Loaded with
// hp-1 in a write cycle, decremented in each wait cycle; o_expire marks the
// last wait cycle of the phase.
module soc_system_pio_seq_timer
  import soc_system_pio_seq_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_expire
);

  logic [CNT_W-1:0] r_cnt;

  // Phase counter: load wins over decrement; never decrements past zero.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_expire = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/soc_system_pio_pulse_seq.sv
// Avalon-MM master sequencer driving a 1-bit output PIO with a train of
// level pulses. Each state's actions (bus write, level, pulses_left) are
// computed on the transition into it, so every output is registered and
// lines up with the state it belongs to.
// Optional build macro PULSE_SEQ_CONTINUOUS_EN: num_pulses==0 at start gives
// an endless train terminated only by abort.
module soc_system_pio_pulse_seq
  import soc_system_pio_seq_pkg::*;
#(
  parameter int   CNT_W      = 16,
  parameter int   NUM_W      = 16,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] half_period,
  input  logic [NUM_W-1:0] num_pulses,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] pulses_left,
  output logic             level,
  output logic [1:0]       avm_address,
  output logic             avm_chipselect,
  output logic             avm_write_n,
  output logic [31:0]      avm_writedata
);

  seq_state_e       r_state, w_nxt_state;
  logic             r_init_wr, w_nxt_init_wr;
  logic             r_abort_wr, w_nxt_abort_wr;
  logic             r_endless, w_nxt_endless;
  logic [NUM_W-1:0] r_pl, w_nxt_pl;
  logic             r_level, w_nxt_level;
  logic [CNT_W-1:0] r_hp;
  logic             r_busy, r_done, r_cs;
  logic [31:0]      r_wdata;
  logic             w_wr, w_wbit, w_hp_load, w_nxt_busy;
  logic             w_hp_one, w_hi_done, w_lo_done, w_cont_en;
  logic             w_tmr_load, w_tmr_dec, w_tmr_expire;

`ifdef PULSE_SEQ_CONTINUOUS_EN
  assign w_cont_en = 1'b1;
`else
  assign w_cont_en = 1'b0;
`endif

  assign w_hp_one   = (r_hp == CNT_W'(1));
  assign w_tmr_load = (r_state == ST_WR_HI) || (r_state == ST_WR_LO);
  assign w_tmr_dec  = (r_state == ST_WAIT_HI) || (r_state == ST_WAIT_LO);
  assign w_hi_done  = ((r_state == ST_WR_HI) && w_hp_one) ||
                      ((r_state == ST_WAIT_HI) && w_tmr_expire);
  assign w_lo_done  = ((r_state == ST_WR_LO) && w_hp_one) ||
                      ((r_state == ST_WAIT_LO) && w_tmr_expire);

  soc_system_pio_seq_timer #(.CNT_W(CNT_W)) u_timer (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_load     (w_tmr_load),
    .i_load_val (r_hp - CNT_W'(1)),
    .i_dec      (w_tmr_dec),
    .o_expire   (w_tmr_expire)
  );

  // Next-state logic plus the write, level and pulse-count actions of the state being entered.
  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_init_wr  = r_init_wr;
    w_nxt_abort_wr = 1'b0;
    w_nxt_endless  = r_endless;
    w_nxt_pl       = r_pl;
    w_nxt_level    = r_level;
    w_wr           = 1'b0;
    w_wbit         = 1'b0;
    w_hp_load      = 1'b0;
    case (r_state)
      ST_INIT: begin
        if (!r_init_wr) begin
          w_nxt_init_wr = 1'b1;
          w_wr          = 1'b1;
          w_wbit        = IDLE_LEVEL;
          w_nxt_level   = IDLE_LEVEL;
        end else begin
          w_nxt_state = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (start && !abort) begin
          w_hp_load = 1'b1;
          w_nxt_pl  = num_pulses;
          if ((num_pulses != '0) || w_cont_en) begin
            w_nxt_state   = ST_WR_HI;
            w_nxt_endless = (num_pulses == '0);
            w_wr          = 1'b1;
            w_wbit        = 1'b1;
            w_nxt_level   = 1'b1;
          end else begin
            w_nxt_state = ST_FINISH;
          end
        end
      end
      ST_WR_HI, ST_WAIT_HI, ST_WR_LO, ST_WAIT_LO: begin
        if (r_abort_wr) begin
          w_nxt_state = ST_FINISH;
        end else if (abort) begin
          w_nxt_pl = '0;
          if (r_level) begin
            w_nxt_state    = ST_WR_LO;
            w_nxt_abort_wr = 1'b1;
            w_wr           = 1'b1;
            w_wbit         = IDLE_LEVEL;
            w_nxt_level    = IDLE_LEVEL;
          end else begin
            w_nxt_state = ST_FINISH;
          end
        end else if (w_hi_done) begin
          w_nxt_state = ST_WR_LO;
          w_wr        = 1'b1;
          w_wbit      = 1'b0;
          w_nxt_level = 1'b0;
          if (!r_endless && (r_pl != '0)) w_nxt_pl = r_pl - NUM_W'(1);
        end else if (w_lo_done) begin
          if (!r_endless && (r_pl == '0)) begin
            w_nxt_state = ST_FINISH;
          end else begin
            w_nxt_state = ST_WR_HI;
            w_wr        = 1'b1;
            w_wbit      = 1'b1;
            w_nxt_level = 1'b1;
          end
        end else if (r_state == ST_WR_HI) begin
          w_nxt_state = ST_WAIT_HI;
        end else if (r_state == ST_WR_LO) begin
          w_nxt_state = ST_WAIT_LO;
        end
      end
      ST_FINISH: begin
        w_nxt_state   = ST_IDLE;
        w_nxt_endless = 1'b0;
      end
      default: begin
        w_nxt_state   = ST_INIT;
        w_nxt_init_wr = 1'b0;
      end
    endcase
  end

  assign w_nxt_busy = !((w_nxt_state == ST_IDLE) || (w_nxt_state == ST_FINISH));

  // Control state and registered outputs; reset returns to INIT with the bus idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_INIT;
      r_init_wr  <= 1'b0;
      r_abort_wr <= 1'b0;
      r_endless  <= 1'b0;
      r_pl       <= '0;
      r_level    <= IDLE_LEVEL;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_cs       <= 1'b0;
      r_wdata    <= '0;
    end else begin
      r_state    <= w_nxt_state;
      r_init_wr  <= w_nxt_init_wr;
      r_abort_wr <= w_nxt_abort_wr;
      r_endless  <= w_nxt_endless;
      r_pl       <= w_nxt_pl;
      r_level    <= w_nxt_level;
      r_busy     <= w_nxt_busy;
      r_done     <= (w_nxt_state == ST_FINISH);
      r_cs       <= w_wr;
      r_wdata    <= w_wr ? pio_wdata(w_wbit) : '0;
    end
  end

  // Half-period latched at start; a request of 0 behaves as 1.
  always_ff @(posedge clk) begin
    if (w_hp_load) begin
      r_hp <= (half_period == '0) ? CNT_W'(1) : half_period;
    end
  end

  assign busy           = r_busy;
  assign done           = r_done;
  assign pulses_left    = r_pl;
  assign level          = r_level;
  assign avm_address    = PIO_DATA_ADDR;
  assign avm_chipselect = r_cs;
  assign avm_write_n    = ~r_cs;
  assign avm_writedata  = r_wdata;

endmodule

// File: tb/tb_soc_system_pio_pulse_seq.sv
// Bench for soc_system_pio_pulse_seq: a negedge monitor logs every bus write,
// done strobe and busy cycle; each scenario builds its expected write
// schedule from the timing rules (k-th high write at 1+2k*hp, done at
// 1+2n*hp, abort truncation) and compares it with the log.
module tb_soc_system_pio_pulse_seq;

`ifdef PULSE_SEQ_CONTINUOUS_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  logic        clk, reset, start, abort;
  logic [15:0] half_period, num_pulses, pulses_left;
  logic        busy, done, level, avm_chipselect, avm_write_n;
  logic [1:0]  avm_address;
  logic [31:0] avm_writedata;

  soc_system_pio_pulse_seq dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .abort          (abort),
    .half_period    (half_period),
    .num_pulses     (num_pulses),
    .busy           (busy),
    .done           (done),
    .pulses_left    (pulses_left),
    .level          (level),
    .avm_address    (avm_address),
    .avm_chipselect (avm_chipselect),
    .avm_write_n    (avm_write_n),
    .avm_writedata  (avm_writedata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          c;
    logic [31:0] d;
    logic [1:0]  a;
    int          pl;
    logic        lv;
  } wr_t;

  wr_t act_q[$];
  int  done_q[$];
  int  busy_q[$];
  int  bad_bus = 0;
  int  n_checks = 0;
  int  n_errs = 0;

  always @(negedge clk) begin
    if (avm_chipselect === 1'b1)
      act_q.push_back('{cyc, avm_writedata, avm_address, int'(pulses_left), level});
    if (done === 1'b1) done_q.push_back(cyc);
    if (busy === 1'b1) busy_q.push_back(cyc);
    if ((avm_chipselect !== ~avm_write_n) || (avm_address !== 2'd0) ||
        ((avm_chipselect !== 1'b1) && (avm_writedata !== 32'd0)))
      bad_bus <= bad_bus + 1;
  end

  task automatic clr_logs();
    act_q.delete();
    done_q.delete();
    busy_q.delete();
  endtask

  // One train: model the schedule, drive it, compare the log.
  task automatic run_train(input int h, input int n, input int ab, input bit glitch,
                           input string tag);
    int ec[$];
    int ev[$];
    int epl[$];
    int hp, dn, k, c0, b0, rel;
    bit endless, lastv;
    hp = (h == 0) ? 1 : h;
    endless = CONT && (n == 0);
    dn = 1;
    if (n != 0 || endless) begin
      k = 0;
      dn = endless ? 0 : 1 + 2 * n * hp;
      while (endless ? (1 + 2 * k * hp <= ab) : (k < n)) begin
        ec.push_back(1 + 2 * k * hp);       ev.push_back(1); epl.push_back(endless ? 0 : n - k);
        ec.push_back(1 + (2 * k + 1) * hp); ev.push_back(0); epl.push_back(endless ? 0 : n - k - 1);
        k++;
      end
      if (ab >= 1 && (endless || ab < dn)) begin
        while (ec.size() > 0 && ec[ec.size()-1] > ab) begin
          void'(ec.pop_back()); void'(ev.pop_back()); void'(epl.pop_back());
        end
        lastv = (ev.size() > 0) ? ev[ev.size()-1][0] : 1'b0;
        if (lastv) begin
          ec.push_back(ab + 1); ev.push_back(0); epl.push_back(0);
          dn = ab + 2;
        end else begin
          dn = ab + 1;
        end
      end
    end

    @(posedge clk); #1;
    clr_logs();
    b0 = bad_bus;
    c0 = cyc;
    start = 1'b1;
    abort = 1'b0;
    half_period = 16'(h);
    num_pulses = 16'(n);
    for (rel = 1; rel <= dn + 3; rel++) begin
      @(posedge clk); #1;
      start = glitch && (rel < dn) && ($urandom_range(0, 2) == 0);
      if (glitch) begin
        half_period = 16'($urandom_range(0, 7));
        num_pulses = 16'($urandom_range(0, 7));
      end
      abort = (rel == ab);
    end
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);

    n_checks++;
    if (act_q.size() != ec.size()) begin
      n_errs++;
      $display("FAIL %s wr_count got %0d want %0d", tag, act_q.size(), ec.size());
    end
    for (int i = 0; i < ec.size() && i < act_q.size(); i++) begin
      n_checks++;
      if (act_q[i].c - c0 != ec[i] || act_q[i].d !== 32'(ev[i]) || act_q[i].a !== 2'd0 ||
          act_q[i].pl != epl[i] || act_q[i].lv !== ev[i][0]) begin
        n_errs++;
        $display("FAIL %s wr%0d got cyc=%0d data=%0h addr=%0d pl=%0d lvl=%0b want cyc=%0d data=%0h addr=0 pl=%0d lvl=%0d",
                 tag, i, act_q[i].c - c0, act_q[i].d, act_q[i].a, act_q[i].pl, act_q[i].lv,
                 ec[i], ev[i], epl[i], ev[i]);
      end
    end
    n_checks++;
    if (done_q.size() != 1) begin
      n_errs++;
      $display("FAIL %s done_count got %0d want 1", tag, done_q.size());
    end else if (done_q[0] - c0 != dn) begin
      n_errs++;
      $display("FAIL %s done_cycle got %0d want %0d", tag, done_q[0] - c0, dn);
    end
    n_checks++;
    if (bad_bus != b0) begin
      n_errs++;
      $display("FAIL %s bus_protocol got %0d bad cycles want 0", tag, bad_bus - b0);
    end
    n_checks++;
    if (busy !== 1'b0 || pulses_left !== 16'd0 || level !== 1'b0) begin
      n_errs++;
      $display("FAIL %s final got busy=%0b pl=%0d lvl=%0b want 0/0/0", tag, busy, pulses_left, level);
    end
  endtask

  task automatic test_reset();
    int r, b0;
    reset = 1'b1; start = 1'b0; abort = 1'b0; half_period = '0; num_pulses = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || pulses_left !== 16'd0 || level !== 1'b0) begin
      n_errs++;
      $display("FAIL reset_status got busy=%0b done=%0b pl=%0d lvl=%0b want 0/0/0/0",
               busy, done, pulses_left, level);
    end
    n_checks++;
    if (avm_chipselect !== 1'b0 || avm_write_n !== 1'b1 || avm_writedata !== 32'd0 || avm_address !== 2'd0) begin
      n_errs++;
      $display("FAIL reset_bus got cs=%0b wn=%0b data=%0h addr=%0d want 0/1/0/0",
               avm_chipselect, avm_write_n, avm_writedata, avm_address);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    r = cyc;
    b0 = bad_bus;
    clr_logs();
    repeat (5) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (act_q.size() != 1) begin
      n_errs++;
      $display("FAIL init_wr_count got %0d want 1", act_q.size());
    end else if (act_q[0].c - r != 1 || act_q[0].d !== 32'd0 || act_q[0].a !== 2'd0) begin
      n_errs++;
      $display("FAIL init_wr got cyc=%0d data=%0h addr=%0d want cyc=1 data=0 addr=0",
               act_q[0].c - r, act_q[0].d, act_q[0].a);
    end
    n_checks++;
    if (busy_q.size() != 1) begin
      n_errs++;
      $display("FAIL init_busy_cycles got %0d want 1", busy_q.size());
    end else if (busy_q[0] - r != 1) begin
      n_errs++;
      $display("FAIL init_busy_cycle got %0d want 1", busy_q[0] - r);
    end
    n_checks++;
    if (done_q.size() != 0 || bad_bus != b0) begin
      n_errs++;
      $display("FAIL init_quiet got done=%0d badbus=%0d want 0/0", done_q.size(), bad_bus - b0);
    end
  endtask

  task automatic test_basic();
    run_train(3, 2, -1, 1'b0, "hp3_n2");
  endtask

  task automatic test_hp_zero();
    run_train(0, 3, -1, 1'b0, "hp0_n3");
  endtask

  task automatic test_abort();
    run_train(10, 5, 25, 1'b0, "abort_wait_hi");
  endtask

  task automatic test_zero_pulses();
`ifdef PULSE_SEQ_CONTINUOUS_EN
    run_train(2, 0, 13, 1'b0, "endless");
    run_train(3, 0, 17, 1'b0, "endless_lo");
`else
    run_train(2, 0, -1, 1'b0, "n0");
`endif
  endtask

  task automatic test_start_abort_idle();
    int c0;
    @(posedge clk); #1;
    clr_logs();
    c0 = cyc;
    start = 1'b1; abort = 1'b1; half_period = 16'd2; num_pulses = 16'd2;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (act_q.size() != 0 || done_q.size() != 0 || busy_q.size() != 0) begin
      n_errs++;
      $display("FAIL start_abort_idle got wr=%0d done=%0d busy=%0d after %0d cycles want 0/0/0",
               act_q.size(), done_q.size(), busy_q.size(), cyc - c0);
    end
  endtask

  task automatic test_busy_start();
    run_train(3, 3, -1, 1'b1, "start_while_busy");
    run_train(1, 4, -1, 1'b1, "start_while_busy_hp1");
  endtask

  task automatic test_back_to_back();
    int h, n, hp, ab;
    for (int t = 0; t < 10; t++) begin
      h = $urandom_range(0, 5);
      n = $urandom_range(0, 4);
      hp = (h == 0) ? 1 : h;
      if (n == 0) ab = CONT ? $urandom_range(1, 20) : -1;
      else ab = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 2 * n * hp) : -1;
      run_train(h, n, ab, $urandom_range(0, 1) == 1, $sformatf("rand%0d_h%0d_n%0d_ab%0d", t, h, n, ab));
    end
  endtask

  task automatic test_reset_mid();
    int c0;
    @(posedge clk); #1;
    clr_logs();
    c0 = cyc;
    start = 1'b1; half_period = 16'd4; num_pulses = 16'd3;
    for (int rel = 1; rel <= 10; rel++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (rel == 6) reset = 1'b1;
      if (rel == 7) begin
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (avm_chipselect !== 1'b0 || avm_write_n !== 1'b1 || busy !== 1'b0 ||
            done !== 1'b0 || pulses_left !== 16'd0) begin
          n_errs++;
          $display("FAIL reset_mid_idle got cs=%0b wn=%0b busy=%0b done=%0b pl=%0d want 0/1/0/0/0",
                   avm_chipselect, avm_write_n, busy, done, pulses_left);
        end
      end
    end
    @(negedge clk);
    n_checks++;
    if (act_q.size() != 3) begin
      n_errs++;
      $display("FAIL reset_mid_wr_count got %0d want 3", act_q.size());
    end else if (act_q[0].c - c0 != 1 || act_q[0].d !== 32'd1 || act_q[1].c - c0 != 5 ||
                 act_q[1].d !== 32'd0 || act_q[2].c - c0 != 8 || act_q[2].d !== 32'd0) begin
      n_errs++;
      $display("FAIL reset_mid_wrs got %0d:%0h %0d:%0h %0d:%0h want 1:1 5:0 8:0",
               act_q[0].c - c0, act_q[0].d, act_q[1].c - c0, act_q[1].d, act_q[2].c - c0, act_q[2].d);
    end
    n_checks++;
    if (done_q.size() != 0) begin
      n_errs++;
      $display("FAIL reset_mid_done got %0d strobes want 0", done_q.size());
    end
    n_checks++;
    if (busy_q.size() != 7 || busy_q[busy_q.size()-1] - c0 != 8 || busy_q[5] - c0 != 6) begin
      n_errs++;
      $display("FAIL reset_mid_busy got %0d busy cycles want 7 (1..6 and 8)", busy_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hp_zero();
    test_abort();
    test_zero_pulses();
    test_start_abort_idle();
    test_busy_start();
    test_back_to_back();
    test_reset_mid();
    test_basic();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
